alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command front-end for `simple_alu`. Accepts whole ALU commands (2-bit op, two operands) over a valid/ready port and buffers them in a small FIFO. Serializes each command onto the ALU's `opcode_valid`/`opcode`/`data` pins, waits for `done`, and returns `result`/`overflow` on a valid/ready response port. Sits directly upstream of `simple_alu` and replaces the hand-driven stimulus path into it.

## Interface
- `WIDTH`, 8: operand/result width; matches the ALU `data`/`result` width.
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT`, 64: max cycles in WAIT before abort; only used when the timeout macro is defined.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  `!full`; a command is accepted on the edge where `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  ALU op code.
- `cmd_a`  in  WIDTH  first operand.
- `cmd_b`  in  WIDTH  second operand.
- `opcode_valid`  out  1  to ALU.
- `opcode`  out  1  to ALU; serial op bit.
- `data`  out  WIDTH  to ALU; operand bus.
- `done`  in  1  from ALU; one-cycle completion pulse.
- `overflow`  in  1  from ALU; valid with `done`.
- `result`  in  WIDTH  from ALU; valid with `done`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed on the edge where `rsp_valid & rsp_ready`.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_overflow`  out  1  captured overflow.
- `rsp_timeout`  out  1  response is a timeout abort; constant 0 when the macro is undefined.

## Operation
- FIFO: `DEPTH` entries of `{op, a, b}`, with read/write pointers one bit wider than the index.
  - Push and pop may occur in the same cycle.
  - `cmd_ready` depends only on `full`; there is no bypass when full and popping.
- FSM states: IDLE, SEND0, SEND1, WAIT, RESP.
- IDLE:
  - FIFO non-empty → pop the head into the working register, go to SEND0.
  - All ALU outputs are 0.
- SEND0: `opcode_valid=1`, `opcode=op[1]`, `data=a` → SEND1.
- SEND1: `opcode_valid=1`, `opcode=op[0]`, `data=b` → WAIT.
- WAIT:
  - ALU outputs are 0.
  - On `done=1`, capture `result`/`overflow` into the response registers, clear `rsp_timeout`, go to RESP.
- RESP:
  - `rsp_valid=1`; response fields are held stable.
  - `rsp_ready=1` → IDLE. The next pop can happen one cycle later, in IDLE.
- `done` seen in IDLE, SEND0, SEND1 or RESP is ignored.
- The block is opcode-agnostic: ops are never decoded or checked.
- Responses are returned in command order. At most one command is in flight at the ALU.
- Reset values of outputs:
  - `cmd_ready=1` (FIFO empty).
  - `opcode_valid`, `opcode`, `data` = 0.
  - `rsp_valid`, `rsp_result`, `rsp_overflow`, `rsp_timeout` = 0.
  - FSM in IDLE; FIFO pointers at 0.
- Reset mid-operation discards the FIFO contents, the in-flight command and any pending response. A `done` arriving after reset is released lands in IDLE and is ignored.

## Timing
- All ALU-side and response outputs are registered; `cmd_ready` is decoded from the registered pointers.
- Command accepted at edge t into an empty FIFO with FSM idle:
  - IDLE pops at t+1.
  - SEND0 at t+2, SEND1 at t+3.
  - WAIT from t+4.
- `done` sampled at edge d → `rsp_valid` high from d+1.
- Minimum command-to-command spacing at the ALU: 4 cycles plus the ALU's done latency plus response stall.
- Full FIFO: `cmd_ready=0` in the cycle after the `DEPTH`-th push completes; it returns to 1 the cycle after a pop.

## Configuration
- `ALU_SEQ_TIMEOUT_EN` defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT` without `done`: `rsp_result=0`, `rsp_overflow=0`, `rsp_timeout=1`, go to RESP.
  - If `done` arrives on the same edge as the limit, `done` wins.
- Undefined:
  - WAIT persists until `done`.
  - No counter is built; `rsp_timeout` is tied to 0.

## Test plan
Bench ALU model: op 2'b00 = add; `done` 3 cycles after SEND1.
1. Single add, `op=00`, a=8'h12, b=8'h34 → ALU sees (1,0,8'h12) then (1,0,8'h34); `rsp_result=8'h46`, `rsp_overflow=0`, `rsp_timeout=0`.
2. Add with carry, a=8'hF0, b=8'h20 → `rsp_result=8'h10`, `rsp_overflow=1`.
3. `rsp_ready` held 0 while pushing continuously, `DEPTH=4` → exactly 5 commands accepted (1 in RESP, 4 in FIFO); `cmd_ready=0` thereafter. Releasing `rsp_ready` drains 5 responses in push order.
4. Three back-to-back commands (1+1, 2+2, 3+3) with `rsp_ready=1` → responses 2, 4, 6 in order; `opcode_valid` high for exactly 2 cycles per command.
5. `ALU_SEQ_TIMEOUT_EN`, `TIMEOUT=64`, ALU never asserts `done` → `rsp_valid` with `rsp_timeout=1`, `rsp_result=0` exactly 65 cycles after WAIT entry. Without the macro: no response after 1000 cycles.
6. Assert `reset` during WAIT with 2 commands queued, then pulse `done` after release → all outputs 0 immediately, `cmd_ready=1`, no `rsp_valid` ever.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for simple_alu: FIFO-buffers {op, a, b} commands, serializes each onto the
// ALU pins, waits for done and returns the result. Define ALU_SEQ_TIMEOUT_EN to bound the wait.
module alu_cmd_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             opcode_valid,
    output logic             opcode,
    output logic [WIDTH-1:0] data,
    input  logic             done,
    input  logic             overflow,
    input  logic [WIDTH-1:0] result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_timeout
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 2 + 2 * WIDTH;

    typedef enum logic [2:0] {StIdle, StSend0, StSend1, StWait, StResp} state_e;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic             full, empty, push, pop;
    logic [EW-1:0]    head;
    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             opcode_valid_q, opcode_valid_d, opcode_q, opcode_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_overflow_q, rsp_overflow_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int unsigned   CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CntMax = CW'(TIMEOUT);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_timeout_q, rsp_timeout_d;
`endif

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state_q == StIdle) && !empty;
    assign head      = mem_q[rptr_q[AW-1:0]];
    assign wptr_d    = wptr_q + (AW + 1)'(push);
    assign rptr_d    = rptr_q + (AW + 1)'(pop);

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        b_d            = b_q;
        opcode_valid_d = 1'b0;
        opcode_d       = 1'b0;
        data_d         = '0;
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_overflow_d = rsp_overflow_q;
`ifdef ALU_SEQ_TIMEOUT_EN
        cnt_d          = cnt_q;
        rsp_timeout_d  = rsp_timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    op_d           = head[EW-1:EW-2];
                    b_d            = head[WIDTH-1:0];
                    opcode_valid_d = 1'b1;
                    opcode_d       = head[EW-1];
                    data_d         = head[2*WIDTH-1:WIDTH];
                    state_d        = StSend0;
                end
            end
            StSend0: begin
                opcode_valid_d = 1'b1;
                opcode_d       = op_q[0];
                data_d         = b_q;
                state_d        = StSend1;
            end
            StSend1: begin
`ifdef ALU_SEQ_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (done) begin
                    rsp_valid_d    = 1'b1;
                    rsp_result_d   = result;
                    rsp_overflow_d = overflow;
`ifdef ALU_SEQ_TIMEOUT_EN
                    rsp_timeout_d  = 1'b0;
`endif
                    state_d        = StResp;
                end
`ifdef ALU_SEQ_TIMEOUT_EN
                else if (cnt_q == CntMax) begin
                    rsp_valid_d    = 1'b1;
                    rsp_result_d   = '0;
                    rsp_overflow_d = 1'b0;
                    rsp_timeout_d  = 1'b1;
                    state_d        = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            state_q        <= StIdle;
            op_q           <= '0;
            b_q            <= '0;
            opcode_valid_q <= 1'b0;
            opcode_q       <= 1'b0;
            data_q         <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
            cnt_q          <= '0;
            rsp_timeout_q  <= 1'b0;
`endif
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            state_q        <= state_d;
            op_q           <= op_d;
            b_q            <= b_d;
            opcode_valid_q <= opcode_valid_d;
            opcode_q       <= opcode_d;
            data_q         <= data_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_overflow_q <= rsp_overflow_d;
`ifdef ALU_SEQ_TIMEOUT_EN
            cnt_q          <= cnt_d;
            rsp_timeout_q  <= rsp_timeout_d;
`endif
        end
    end

    assign opcode_valid = opcode_valid_q;
    assign opcode       = opcode_q;
    assign data         = data_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_overflow_q;
`ifdef ALU_SEQ_TIMEOUT_EN
    assign rsp_timeout  = rsp_timeout_q;
`else
    assign rsp_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU (done 3 cycles after the 2nd word).
module tb_alu_cmd_sequencer;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0, cmd_ready;
    logic [1:0]       cmd_op = '0;
    logic [WIDTH-1:0] cmd_a = '0, cmd_b = '0;
    logic             opcode_valid, opcode;
    logic [WIDTH-1:0] data;
    logic             done = 1'b0, overflow = 1'b0;
    logic [WIDTH-1:0] result = '0;
    logic             rsp_valid, rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_overflow, rsp_timeout;

    typedef struct { logic [1:0] op; logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; } cmd_t;
    typedef struct { logic [WIDTH-1:0] r; logic ov; logic to; } rsp_t;

    cmd_t alu_exp_q[$];
    rsp_t rsp_exp_q[$];
    int   checks = 0, errors = 0;
    int   accepted = 0, rsp_valid_cycles = 0, pulse_cnt = 0;
    bit   alu_enable = 1'b1, rand_mode = 1'b0;
    logic rsp_ready_cmd = 1'b1;

    alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .opcode_valid(opcode_valid),
        .opcode(opcode), .data(data), .done(done), .overflow(overflow), .result(result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    // Reference ALU: {overflow, result}. op 0 add (carry), 1 sub (borrow), 2 and, 3 xor.
    function automatic logic [WIDTH:0] ref_alu(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Accept monitor: records every handshake and the response it should eventually produce.
    initial forever begin
        @(negedge clk);
        if (!reset && cmd_valid && cmd_ready) begin
            cmd_t c;
            rsp_t r;
            logic [WIDTH:0] v;
            c.op = cmd_op; c.a = cmd_a; c.b = cmd_b;
            alu_exp_q.push_back(c);
            accepted++;
            if (alu_enable) begin
                v = ref_alu(cmd_op, cmd_a, cmd_b);
                r.r = v[WIDTH-1:0]; r.ov = v[WIDTH]; r.to = 1'b0;
                rsp_exp_q.push_back(r);
            end
`ifdef ALU_SEQ_TIMEOUT_EN
            else begin
                r.r = '0; r.ov = 1'b0; r.to = 1'b1;
                rsp_exp_q.push_back(r);
            end
`endif
        end
    end

    // Response monitor.
    initial forever begin
        @(negedge clk);
        if (!reset && rsp_valid) rsp_valid_cycles++;
        if (!reset && rsp_valid && rsp_ready) begin
            if (rsp_exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_result), 32'hDEAD_BEEF);
            end else begin
                rsp_t e;
                e = rsp_exp_q.pop_front();
                check("rsp_result", 32'(rsp_result), 32'(e.r));
                check("rsp_overflow", 32'(rsp_overflow), 32'(e.ov));
                check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
            end
        end
    end

    // Behavioural ALU plus pin-level checks of the serialized command.
    initial begin
        int run = 0, phase = 0, cnt = 0, pulses_seen = 0;
        logic op1 = 1'b0, op0 = 1'b0;
        logic [WIDTH-1:0] ra = '0, rb = '0;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (reset) begin
                run = 0; phase = 0; cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        done = 1'b1;
                        {overflow, result} = ref_alu({op1, op0}, ra, rb);
                    end
                end
                if (pulse_cnt != pulses_seen) begin
                    pulses_seen = pulse_cnt;
                    done = 1'b1; overflow = 1'b1; result = WIDTH'($urandom);
                end
                if (opcode_valid) begin
                    run++;
                    if (phase == 0) begin
                        op1 = opcode; ra = data; phase = 1;
                    end else begin
                        op0 = opcode; rb = data; phase = 0;
                        if (alu_exp_q.size() == 0) begin
                            check("alu_unexpected_cmd", {op1, op0, ra, rb}, 32'hDEAD_BEEF);
                        end else begin
                            cmd_t e;
                            e = alu_exp_q.pop_front();
                            check("alu_cmd", {op1, op0, ra, rb}, {e.op, e.a, e.b});
                        end
                        if (alu_enable) cnt = 3;
                    end
                end else if (run != 0) begin
                    check("opcode_valid_len", run, 2);
                    run = 0;
                end
            end
        end
    end

    // Sole driver of rsp_ready.
    initial forever begin
        @(posedge clk); #1;
        rsp_ready = rand_mode ? 1'($urandom_range(0, 1)) : rsp_ready_cmd;
    end

    task automatic push(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit ok = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("push_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rsp_exp_q.size() == 0 && alu_exp_q.size() == 0 && !rsp_valid) begin
                ok = 1'b1; break;
            end
        end
        check("drain", 32'(ok), 1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        check({tag, "_opcode_valid"}, 32'(opcode_valid), 0);
        check({tag, "_opcode"}, 32'(opcode), 0);
        check({tag, "_data"}, 32'(data), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_result"}, 32'(rsp_result), 0);
        check({tag, "_rsp_overflow"}, 32'(rsp_overflow), 0);
        check({tag, "_rsp_timeout"}, 32'(rsp_timeout), 0);
    endtask

    task automatic apply_reset(input string tag);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        alu_exp_q.delete();
        rsp_exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0, n, v0;
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single add with pin-level timing from the accepting edge.
        push(2'b00, 8'h12, 8'h34);
        @(negedge clk); check("t1_idle_gap", 32'(opcode_valid), 0);
        @(negedge clk); check("t1_send0", {opcode_valid, opcode, data}, {1'b1, 1'b0, 8'h12});
        @(negedge clk); check("t1_send1", {opcode_valid, opcode, data}, {1'b1, 1'b0, 8'h34});
        @(negedge clk); check("t1_wait", {opcode_valid, opcode, data}, 0);
        @(posedge clk); #1;
        wait_drain();

        // Add with carry out.
        push(2'b00, 8'hF0, 8'h20);
        wait_drain();

        // Stalled response: one command in RESP plus a full FIFO.
        rsp_ready_cmd = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        acc0 = accepted;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cmd_op = 2'($urandom); cmd_a = WIDTH'($urandom); cmd_b = WIDTH'($urandom);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("t3_accepted", accepted - acc0, DEPTH + 1);
        check("t3_cmd_ready_full", 32'(cmd_ready), 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rsp_ready_cmd = 1'b1;
        wait_drain();

        // Back-to-back commands.
        push(2'b00, 8'd1, 8'd1);
        push(2'b00, 8'd2, 8'd2);
        push(2'b00, 8'd3, 8'd3);
        wait_drain();

        // ALU never answers.
        alu_enable = 1'b0;
        push(2'($urandom), WIDTH'($urandom), WIDTH'($urandom));
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (opcode_valid) begin ok = 1'b1; break; end
        end
        for (int i = 0; i < 10 && opcode_valid; i++) @(negedge clk);
        check("t5_sent", 32'(ok), 1);
`ifdef ALU_SEQ_TIMEOUT_EN
        n = 0;
        while (!rsp_valid && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("t5_timeout_latency", n, TIMEOUT + 1);
        @(posedge clk); #1;
        wait_drain();
`else
        v0 = rsp_valid_cycles;
        repeat (1000) @(negedge clk);
        check("t5_no_response", rsp_valid_cycles - v0, 0);
        apply_reset("t5_reset");
`endif

        // Reset while a command waits and two more are queued, then a stray done.
        push(2'b00, 8'd5, 8'd6);
        push(2'b01, 8'd7, 8'd8);
        push(2'b10, 8'd9, 8'd10);
        repeat (4) @(negedge clk);
        apply_reset("t6_reset");
        v0 = rsp_valid_cycles;
        pulse_cnt++;
        repeat (20) @(negedge clk);
        check("t6_no_rsp", rsp_valid_cycles - v0, 0);
        check("t6_cmd_ready", 32'(cmd_ready), 1);
        check("t6_opcode_valid", 32'(opcode_valid), 0);
        alu_enable = 1'b1;
        @(posedge clk); #1;

        // Random traffic with random response back-pressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(2'($urandom), WIDTH'($urandom), WIDTH'($urandom));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        rand_mode = 1'b0;
        rsp_ready_cmd = 1'b1;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
